// File: rtl/alu_seq.sv
// alu_seq: registered execute unit with logic, arithmetic, iterative shift/rotate and multiply; ALU_SEQ_FAST_MUL_EN selects single-cycle MUL
module alu_seq #(
  parameter int WIDTH = 20,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
  state_t             st_q;
  logic [3:0]         op_q;
  logic               mode_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   sh_q, res_q;
  logic [2*WIDTH-1:0] mc_q, acc_q;
  logic               c_q, z_q, s_q, v_q;
  function automatic logic [WIDTH-1:0] msk(input logic md);
    return md ? {WIDTH{1'b1}} : {{(WIDTH-H){1'b0}}, {H{1'b1}}};
  endfunction
  function automatic logic top(input logic [WIDTH-1:0] v, input logic md);
    return md ? v[WIDTH-1] : v[H-1];
  endfunction
  function automatic logic hinz(input logic [2*WIDTH-1:0] p, input logic md);
    return md ? |p[2*WIDTH-1:WIDTH] : |p[2*WIDTH-1:H];
  endfunction
  logic [WIDTH-1:0]   mi, mq, hb, am, bm, x, ar, lg, sh_d, imm_r, fin_r;
  logic [WIDTH:0]     s, d;
  logic [2*WIDTH-1:0] prod_f, acc_d;
  logic [SHW-1:0]     n;
  logic               sub, ar_c, ar_v, sa, sx, sr, go_sh, mul_it, imm, last, upd;
  logic               sh_out, imm_c, imm_v, fin_c, fin_v, fin_md;
`ifdef ALU_SEQ_FAST_MUL_EN
  assign prod_f = {{WIDTH{1'b0}}, am} * {{WIDTH{1'b0}}, bm};
`else
  assign prod_f = '0;
`endif
  // operand masking, single-cycle datapath, one shift/multiply step, and completion values
  always_comb begin
    mi     = msk(mode);
    mq     = msk(mode_q);
    hb     = mq & ~(mq >> 1);
    am     = a & mi;
    bm     = b & mi;
    n      = b[SHW-1:0];
    sub    = op inside {4'd7, 4'd8, 4'd10};
    x      = (op == 4'd9 || op == 4'd10) ? {{(WIDTH-1){1'b0}}, 1'b1} : bm;
    s      = {1'b0, am} + {1'b0, x} + {{WIDTH{1'b0}}, op == 4'd6 && c_q};
    d      = {1'b0, am} - {1'b0, x} - {{WIDTH{1'b0}}, op == 4'd8 && c_q};
    ar     = (sub ? d[WIDTH-1:0] : s[WIDTH-1:0]) & mi;
    ar_c   = sub ? d[WIDTH] : (mode ? s[WIDTH] : s[H]);
    sa     = top(am, mode);
    sx     = top(x, mode);
    sr     = top(ar, mode);
    ar_v   = sub ? (sa != sx) && (sr != sa) : (sa == sx) && (sr != sa);
    lg     = op == 4'd1 ? ~am & mi : op == 4'd2 ? am & bm : op == 4'd3 ? am | bm : am ^ bm;
    go_sh  = op >= 4'd11 && op <= 4'd14 && n != '0;
    mul_it = op == 4'd15 && !FAST;
    imm    = st_q == IDLE && start && !go_sh && !mul_it;
    last   = (st_q == SHIFT || st_q == MUL) && cnt_q == CW'(1);
    upd    = (imm && op != 4'd0) || last;
    imm_r  = op <= 4'd4 ? lg : op <= 4'd10 ? ar : op == 4'd15 ? prod_f[WIDTH-1:0] & mi : am;
    imm_c  = op <= 4'd4 ? 1'b0 : op <= 4'd10 ? ar_c : op == 4'd15 ? hinz(prod_f, mode) : c_q;
    imm_v  = op >= 4'd5 && op <= 4'd10 && ar_v;
    sh_out = (op_q == 4'd11 || op_q == 4'd13) ? top(sh_q, mode_q) : sh_q[0];
    sh_d   = op_q == 4'd11 ? (sh_q << 1) & mq :
             op_q == 4'd12 ? sh_q >> 1 :
             op_q == 4'd13 ? ((sh_q << 1) | {{(WIDTH-1){1'b0}}, sh_out}) & mq :
                             (sh_q >> 1) | (sh_out ? hb : '0);
    acc_d  = acc_q + (sh_q[0] ? mc_q : '0);
    fin_md = st_q == IDLE ? mode : mode_q;
    fin_r  = st_q == SHIFT ? sh_d : st_q == MUL ? acc_d[WIDTH-1:0] & mq : imm_r;
    fin_c  = st_q == SHIFT ? sh_out : st_q == MUL ? hinz(acc_d, mode_q) : imm_c;
    fin_v  = st_q == IDLE && imm_v;
  end
  // control FSM with status register; result and flags change only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      op_q   <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      mc_q   <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      s_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      if (upd) begin
        res_q <= fin_r;
        c_q   <= fin_c;
        v_q   <= fin_v;
        z_q   <= fin_r == '0;
        s_q   <= top(fin_r, fin_md);
      end
      case (st_q)
        IDLE: if (start) begin
          op_q   <= op;
          mode_q <= mode;
          acc_q  <= '0;
          sh_q   <= mul_it ? bm : am;
          mc_q   <= {{WIDTH{1'b0}}, am};
          cnt_q  <= go_sh ? CW'(n) : mode ? CW'(WIDTH) : CW'(H);
          st_q   <= go_sh ? SHIFT : mul_it ? MUL : DONE;
        end
        SHIFT, MUL: begin
          sh_q  <= st_q == MUL ? sh_q >> 1 : sh_d;
          acc_q <= acc_d;
          mc_q  <= mc_q << 1;
          cnt_q <= cnt_q - 1'b1;
          if (last) st_q <= DONE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign result   = res_q;
  assign carry    = c_q;
  assign zero     = z_q;
  assign sign     = s_q;
  assign overflow = v_q;
  assign busy     = st_q == SHIFT || st_q == MUL;
  assign done     = st_q == DONE;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a scoreboard checking completion cycle, result and flags
module tb_alu_seq;
  localparam int W = 20;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int MUL_F = FAST ? 1 : 21;
  localparam int MUL_H = FAST ? 1 : 11;
  logic clk = 0, rst = 1, start = 0, mode = 1;
  logic [3:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] result;
  logic carry, zero, sign, overflow, busy, done;
  typedef struct { int cyc; logic [W+3:0] v; } exp_t;
  exp_t sb[$];
  exp_t e_m;
  int cyc = 0, checks = 0, failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .mode(mode), .a(a), .b(b),
    .result(result), .carry(carry), .zero(zero), .sign(sign), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (done) begin
    if (sb.size() == 0) chk("unexpected_done", 1, 0);
    else begin
      e_m = sb.pop_front();
      chk("done_cycle", 64'(cyc), 64'(e_m.cyc));
      chk("res_flags", {result, carry, zero, sign, overflow}, e_m.v);
    end
  end

  task automatic go(input logic [3:0] o, input logic md, input logic [W-1:0] x, input logic [W-1:0] y,
                    input int lat, input logic [W-1:0] r, input logic c, input logic z, input logic s, input logic v);
    @(posedge clk); #1;
    op = o; mode = md; a = x; b = y; start = 1;
    sb.push_back('{cyc + lat, {r, c, z, s, v}});
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 0);
      sb.delete();
    end
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, sign, overflow}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    go(4'd5, 1, 'hFFFFF, 'h00001, 1, 'h00000, 1, 1, 0, 0);
    chk("add_busy", busy, 0);
    drain();
    go(4'd6, 1, 'h0, 'h0, 1, 'h00001, 0, 0, 0, 0); drain();
    go(4'd7, 0, 'h00003, 'h00005, 1, 'h003FE, 1, 0, 1, 0); drain();
    go(4'd11, 1, 'h80001, 'h3, 4, 'h00008, 0, 0, 0, 0);
    chk("shl_busy_n1", {busy, done}, 2'b10);
    @(posedge clk); #1;
    op = 4'd5; a = 'h1; b = 'h1; start = 1;
    chk("shl_busy_n2", busy, 1);
    @(posedge clk); #1;
    start = 0;
    chk("shl_busy_n3", busy, 1);
    drain();
    go(4'd15, 1, 'h00400, 'h00400, MUL_F, 'h00000, 1, 1, 0, 0); drain();
    go(4'd2, 0, 'hFFFFF, 'h0F0F0, 1, 'h000F0, 0, 0, 0, 0); drain();
    go(4'd1, 1, 'h0000F, 'h0, 1, 'hFFFF0, 0, 0, 1, 0); drain();
    go(4'd3, 1, 'h12300, 'h00045, 1, 'h12345, 0, 0, 0, 0); drain();
    go(4'd4, 1, 'hAAAAA, 'hAAAAA, 1, 'h00000, 0, 1, 0, 0); drain();
    go(4'd7, 1, 'h80000, 'h00001, 1, 'h7FFFF, 0, 0, 0, 1); drain();
    go(4'd7, 1, 'h00000, 'h00001, 1, 'hFFFFF, 1, 0, 1, 0); drain();
    go(4'd8, 1, 'h00005, 'h00002, 1, 'h00002, 0, 0, 0, 0); drain();
    go(4'd9, 1, 'h7FFFF, 'h0, 1, 'h80000, 0, 0, 1, 1); drain();
    go(4'd10, 0, 'h00000, 'h0, 1, 'h003FF, 1, 0, 1, 0); drain();
    go(4'd14, 1, 'h00001, 'h1, 2, 'h80000, 1, 0, 1, 0); drain();
    go(4'd13, 0, 'h00200, 'h2, 3, 'h00002, 0, 0, 0, 0); drain();
    go(4'd12, 1, 'h00006, 'h2, 3, 'h00001, 1, 0, 0, 0); drain();
    go(4'd11, 1, 'h12345, 'h0, 1, 'h12345, 1, 0, 0, 0); drain();
    go(4'd0, 1, 'h55555, 'h3, 1, 'h12345, 1, 0, 0, 0); drain();
    go(4'd15, 0, 'h00013, 'h00005, MUL_H, 'h0005F, 0, 0, 0, 0); drain();
    go(4'd5, 0, 'h001FF, 'h00001, 1, 'h00200, 0, 0, 1, 1); drain();
    go(4'd5, 0, 'hFFFFF, 'hFFFFF, 1, 'h003FE, 1, 0, 1, 0); drain();
    @(posedge clk); #1;
    op = 4'd15; mode = 1; a = 'h3; b = 'h5; start = 1;
    c0 = cyc;
    if (FAST) sb.push_back('{c0 + 1, {20'h0000F, 1'b0, 1'b0, 1'b0, 1'b0}});
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_cycle", 64'(cyc), 64'(c0 + 6));
    chk("abort_busy_done", {busy, done}, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {carry, zero, sign, overflow}, 0);
    go(4'd5, 1, 'h00010, 'h00020, 1, 'h00030, 0, 0, 0, 0); drain();
    repeat (30) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
